alu_uart_ctrl: RTL and testbench

Frame sequencer that lets a host PC drive the shared ALU over the serial link. It sits between the UART receiver/transmitter pair and the ALU. It collects three received bytes (operand A, operand B, opcode) into registers that feed the ALU, samples the ALU result, and hands it to the transmitter with a start/done handshake. Incomplete frames are discarded after a programmable idle timeout.

---
 rtl/tp_pkg.sv | 29 ++
 rtl/alu_uart_ctrl_timeout_counter.sv | 31 +++
 rtl/alu_uart_ctrl.sv | 114 +++++++++++
 tb/tb_alu_uart_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tp_pkg.sv
// Shared definitions for the serial ALU front-end: default bus widths and the
// frame sequencer state encoding.
package tp_pkg;

  localparam int N_BUS = 8;
  localparam int N_OP  = 6;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    EXEC    = ST_EXEC,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  // Only the middle of a frame is subject to the idle timeout.
  function automatic logic is_collecting(input state_t s);
    return (s == WAIT_B) || (s == WAIT_OP);
  endfunction

endpackage

// File: rtl/alu_uart_ctrl_timeout_counter.sv
// Idle cycle counter for partially received frames. A TIMEOUT_CYC of zero
// never expires.
module timeout_counter #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  logic [CW-1:0] count;

  // Saturates at LAST so a held enable cannot wrap back to a non-expired value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYC > 0) && enable && (count == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Frame sequencer between the UART pair and the shared ALU: collects A, B and
// opcode bytes, samples the result and hands it to the transmitter.
module alu_uart_ctrl
  import tp_pkg::*;
#(
  parameter int N_BUS       = tp_pkg::N_BUS,
  parameter int N_OP        = tp_pkg::N_OP,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx_done,
  input  logic [N_BUS-1:0] i_rx_data,
  input  logic             i_tx_done,
  input  logic [N_BUS-1:0] i_alu_res,
  output logic [N_BUS-1:0] o_alu_a,
  output logic [N_BUS-1:0] o_alu_b,
  output logic [N_OP-1:0]  o_alu_op,
  output logic             o_tx_start,
  output logic [N_BUS-1:0] o_tx_data,
  output logic             o_busy,
  output logic             o_timeout
);

  state_t state;
  state_t next_state;
  logic   collecting;
  logic   tmo_clear;
  logic   tmo_enable;
  logic   tmo_expired;

  assign collecting = is_collecting(state);
  assign tmo_clear  = !collecting || i_rx_done;
  assign tmo_enable = collecting && !i_rx_done;

  timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= WAIT_A;
    end else begin
      state <= next_state;
    end
  end

  // A received byte always beats an expiry landing in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_A:  if (i_rx_done) next_state = WAIT_B;
      WAIT_B: begin
        if (i_rx_done)        next_state = WAIT_OP;
        else if (tmo_expired) next_state = WAIT_A;
      end
      WAIT_OP: begin
        if (i_rx_done)        next_state = EXEC;
        else if (tmo_expired) next_state = WAIT_A;
      end
      EXEC:    next_state = SEND;
      SEND:    next_state = WAIT_TX;
      WAIT_TX: if (i_tx_done) next_state = WAIT_A;
      default: next_state = WAIT_A;
    endcase
  end

  always_comb begin
    o_busy     = 1'b0;
    o_tx_start = 1'b0;
    case (state)
      EXEC:    o_busy = 1'b1;
      SEND: begin
        o_busy     = 1'b1;
        o_tx_start = 1'b1;
      end
      WAIT_TX: o_busy = 1'b1;
      default: begin
        o_busy     = 1'b0;
        o_tx_start = 1'b0;
      end
    endcase
  end

  // Operands survive a timeout; only a newly accepted byte replaces them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
    end else begin
      if ((state == WAIT_A) && i_rx_done)  o_alu_a  <= i_rx_data;
      if ((state == WAIT_B) && i_rx_done)  o_alu_b  <= i_rx_data;
      if ((state == WAIT_OP) && i_rx_done) o_alu_op <= i_rx_data[N_OP-1:0];
      if (state == EXEC)                   o_tx_data <= i_alu_res;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= collecting && !i_rx_done && tmo_expired;
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench: directed and randomized frames against a byte-level
// model of the protocol with an arithmetic ALU stand-in.
module tb_alu_uart_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic       i_tx_done;
  logic [7:0] i_alu_res;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_timeout;

  int checks = 0;
  int errors = 0;
  int tx_starts = 0;
  int timeouts = 0;

  alu_uart_ctrl #(
    .N_BUS(8),
    .N_OP(6),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_done  (i_rx_done),
    .i_rx_data  (i_rx_data),
    .i_tx_done  (i_tx_done),
    .i_alu_res  (i_alu_res),
    .o_alu_a    (o_alu_a),
    .o_alu_b    (o_alu_b),
    .o_alu_op   (o_alu_op),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return sa >>> b[2:0];
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_res = alu_model(o_alu_a, o_alu_b, o_alu_op);

  always @(negedge i_clk) begin
    if (o_tx_start === 1'b1) tx_starts++;
    if (o_timeout === 1'b1)  timeouts++;
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    i_rx_done = 1'b1;
    i_rx_data = b;
    @(negedge i_clk);
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check8({tag, "_a"}, o_alu_a, 8'h00);
    check8({tag, "_b"}, o_alu_b, 8'h00);
    check8({tag, "_op"}, {2'b00, o_alu_op}, 8'h00);
    check8({tag, "_txdata"}, o_tx_data, 8'h00);
    check1({tag, "_txstart"}, o_tx_start, 1'b0);
    check1({tag, "_busy"}, o_busy, 1'b0);
    check1({tag, "_timeout"}, o_timeout, 1'b0);
  endtask

  // Full frame with `gap` idle cycles between bytes and `txlat` cycles of
  // transmitter time before tx_done.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] opb, input int gap, input int txlat);
    int s0;
    int t0;
    logic [7:0] exp_res;
    s0 = tx_starts;
    t0 = timeouts;
    exp_res = alu_model(a, b, opb[5:0]);
    pulse_rx(a);
    idle(gap);
    pulse_rx(b);
    idle(gap);
    pulse_rx(opb);
    check8({tag, "_a"}, o_alu_a, a);
    check8({tag, "_b"}, o_alu_b, b);
    check8({tag, "_op"}, {2'b00, o_alu_op}, {2'b00, opb[5:0]});
    check1({tag, "_busy_exec"}, o_busy, 1'b1);
    check1({tag, "_start_exec"}, o_tx_start, 1'b0);
    @(negedge i_clk);
    check1({tag, "_start_send"}, o_tx_start, 1'b1);
    check8({tag, "_txdata"}, o_tx_data, exp_res);
    @(negedge i_clk);
    check1({tag, "_start_after"}, o_tx_start, 1'b0);
    idle(txlat);
    check1({tag, "_busy_wait"}, o_busy, 1'b1);
    pulse_tx_done();
    check1({tag, "_busy_done"}, o_busy, 1'b0);
    check8({tag, "_txdata_hold"}, o_tx_data, exp_res);
    check_int({tag, "_nstart"}, tx_starts - s0, 1);
    check_int({tag, "_ntimeout"}, timeouts - t0, 0);
  endtask

  initial begin
    logic [7:0] ops [8];
    int s0;
    int t0;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    i_rst_n   = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    i_tx_done = 1'b0;
    #3 i_rst_n = 1'b0;
    idle(2);
    check_all_zero("reset");
    i_rst_n = 1'b1;
    idle(2);

    // Basic ADD frame, back-to-back bytes.
    run_frame("add", 8'h05, 8'h03, 8'h20, 0, 2);

    // Opcode upper bits dropped; early tx_done in SEND and rx in WAIT_TX ignored.
    pulse_rx(8'h0A);
    pulse_rx(8'h04);
    pulse_rx(8'hE2);
    check8("op_mask", {2'b00, o_alu_op}, 8'h22);
    @(negedge i_clk);
    check1("ign_send_start", o_tx_start, 1'b1);
    check8("ign_txdata", o_tx_data, 8'h06);
    pulse_tx_done();
    check1("ign_busy_after_early_done", o_busy, 1'b1);
    pulse_rx(8'h77);
    pulse_rx(8'h55);
    idle(3);
    check1("ign_busy_after_rx", o_busy, 1'b1);
    check8("ign_a_kept", o_alu_a, 8'h0A);
    check8("ign_b_kept", o_alu_b, 8'h04);
    check8("ign_op_kept", {2'b00, o_alu_op}, 8'h22);
    pulse_tx_done();
    check1("ign_busy_released", o_busy, 1'b0);

    // No timeout while waiting for A.
    t0 = timeouts;
    idle(40);
    check_int("no_timeout_wait_a", timeouts - t0, 0);

    // Timeout in WAIT_B: pulse lands 16 cycles after the A byte.
    t0 = timeouts;
    pulse_rx(8'h11);
    for (int i = 1; i <= 16; i++) begin
      @(negedge i_clk);
      if (i == 15) check1("tmo_before", o_timeout, 1'b0);
      if (i == 16) check1("tmo_pulse", o_timeout, 1'b1);
    end
    idle(4);
    check_int("tmo_count_b", timeouts - t0, 1);
    check8("tmo_a_kept", o_alu_a, 8'h11);
    check1("tmo_not_busy", o_busy, 1'b0);
    run_frame("after_tmo", 8'h30, 8'h12, 8'h22, 1, 1);

    // Timeout in WAIT_OP keeps B.
    t0 = timeouts;
    pulse_rx(8'h21);
    pulse_rx(8'h42);
    idle(20);
    check_int("tmo_count_op", timeouts - t0, 1);
    check8("tmo_b_kept", o_alu_b, 8'h42);

    // Bytes arriving exactly on the expiry cycle win.
    run_frame("edge", 8'h7F, 8'h01, 8'h20, 15, 0);

    // Asynchronous reset mid-WAIT_TX.
    pulse_rx(8'h09);
    pulse_rx(8'h02);
    pulse_rx(8'h20);
    idle(2);
    s0 = tx_starts;
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("rst_wait_tx");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    pulse_tx_done();
    idle(10);
    check_int("rst_wait_tx_nostart", tx_starts - s0, 0);
    check1("rst_wait_tx_idle", o_busy, 1'b0);

    // Asynchronous reset mid-WAIT_OP.
    s0 = tx_starts;
    pulse_rx(8'h33);
    pulse_rx(8'h44);
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("rst_wait_op");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(10);
    check_int("rst_wait_op_nostart", tx_starts - s0, 0);
    run_frame("after_rst", 8'hF0, 8'h03, 8'h03, 0, 3);

    // Randomized frames.
    for (int n = 0; n < 20; n++) begin
      run_frame("rand", 8'($urandom), 8'($urandom),
                {2'($urandom), ops[$urandom_range(0, 7)][5:0]},
                $urandom_range(0, 15), $urandom_range(0, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
